mem_port_arbiter: RTL and testbench

Arbitrates the single shared memory port of the RISC-V core between the instruction-fetch path (PC-driven) and the load/store path. Each requester issues one outstanding request. The arbiter grants the memory, waits for the variable-latency acknowledge, and returns a one-cycle ready pulse with read data. Data accesses have priority, with a bounded-starvation rule for fetch and a watchdog that terminates hung transactions with an error.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; data wins unless fetch has waited StarveLimit grants.
// Latency: grant+1 to mem_req, ready one cycle after mem_ack or after Timeout cycles (err); requesters hold until ready.
module mem_port_arbiter #(
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int StarveLimit = 4,
    parameter int Timeout     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   if_req,
    input  logic [AddrWidth-1:0]   if_addr,
    output logic                   if_ready,
    output logic [DataWidth-1:0]   if_rdata,
    output logic                   if_err,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [AddrWidth-1:0]   d_addr,
    input  logic [DataWidth-1:0]   d_wdata,
    input  logic [DataWidth/8-1:0] d_wstrb,
    output logic                   d_ready,
    output logic [DataWidth-1:0]   d_rdata,
    output logic                   d_err,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [AddrWidth-1:0]   mem_addr,
    output logic [DataWidth-1:0]   mem_wdata,
    output logic [DataWidth/8-1:0] mem_wstrb,
    input  logic                   mem_ack,
    input  logic [DataWidth-1:0]   mem_rdata,
    output logic                   busy
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int StreakW   = $clog2(StarveLimit + 1);
    localparam int WdogW     = $clog2(Timeout + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(StarveLimit);
    localparam logic [WdogW-1:0]   WdogLast  = WdogW'(Timeout - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

    state_t                 state_q, state_nxt;
    logic [StreakW-1:0]     streak_q, streak_nxt;
    logic [WdogW-1:0]       wdog_q, wdog_nxt;

    logic                   mem_req_nxt, mem_we_nxt;
    logic [AddrWidth-1:0]   mem_addr_nxt;
    logic [DataWidth-1:0]   mem_wdata_nxt;
    logic [StrbWidth-1:0]   mem_wstrb_nxt;
    logic                   if_ready_nxt, if_err_nxt, d_ready_nxt, d_err_nxt;
    logic [DataWidth-1:0]   if_rdata_nxt, d_rdata_nxt;
    logic                   busy_nxt;
    logic                   data_win;

    // Fetch overrides data only once it has been passed over StarveLimit times in a row.
    assign data_win = d_req && (!if_req || (streak_q < StreakMax));

    always_comb begin
        state_nxt     = state_q;
        streak_nxt    = streak_q;
        wdog_nxt      = wdog_q;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_wstrb_nxt = mem_wstrb;
        if_ready_nxt  = 1'b0;
        if_err_nxt    = 1'b0;
        d_ready_nxt   = 1'b0;
        d_err_nxt     = 1'b0;
        if_rdata_nxt  = if_rdata;
        d_rdata_nxt   = d_rdata;

        case (state_q)
            IDLE: begin
                if (data_win) begin
                    state_nxt     = DATA;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                    mem_wstrb_nxt = d_wstrb;
                    wdog_nxt      = '0;
                    if (!if_req) begin
                        streak_nxt = '0;
                    end else if (streak_q != StreakMax) begin
                        streak_nxt = streak_q + 1'b1;
                    end
                end else if (if_req) begin
                    state_nxt     = FETCH;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = if_addr;
                    mem_wstrb_nxt = '0;
                    wdog_nxt      = '0;
                    streak_nxt    = '0;
                end
            end

            FETCH, DATA: begin
                // An ack on the final watchdog cycle still completes normally.
                if (mem_ack) begin
                    state_nxt   = RESP;
                    mem_req_nxt = 1'b0;
                    if (state_q == FETCH) begin
                        if_ready_nxt = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end else begin
                        d_ready_nxt = 1'b1;
                        if (!mem_we) begin
                            d_rdata_nxt = mem_rdata;
                        end
                    end
                end else if (wdog_q == WdogLast) begin
                    state_nxt   = RESP;
                    mem_req_nxt = 1'b0;
                    if (state_q == FETCH) begin
                        if_ready_nxt = 1'b1;
                        if_err_nxt   = 1'b1;
                        if_rdata_nxt = '0;
                    end else begin
                        d_ready_nxt = 1'b1;
                        d_err_nxt   = 1'b1;
                        if (!mem_we) begin
                            d_rdata_nxt = '0;
                        end
                    end
                end else begin
                    wdog_nxt = wdog_q + 1'b1;
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            wdog_q    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_ready  <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_ready   <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            streak_q  <= streak_nxt;
            wdog_q    <= wdog_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_wstrb <= mem_wstrb_nxt;
            if_ready  <= if_ready_nxt;
            if_err    <= if_err_nxt;
            if_rdata  <= if_rdata_nxt;
            d_ready   <= d_ready_nxt;
            d_err     <= d_err_nxt;
            d_rdata   <= d_rdata_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LIM = 4;
    localparam int TO  = 16;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_d_load = 32'h0;

    mem_port_arbiter #(
        .AddrWidth(32), .DataWidth(32), .StarveLimit(LIM), .Timeout(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick; tick;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_ready, if_rdata, if_err,
             d_ready, d_rdata, d_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h busy=%b, expected all 0", mem_req, mem_we, mem_addr, busy);
        end
        reset = 1'b1;
        tick;
        checks++;
        if ({busy, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b mem_req=%b expected 0 0", busy, mem_req);
        end
    endtask

    task automatic test_single_fetch;
        if_req = 1'b1; if_addr = 32'h0000_0010;
        tick;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {1'b1, 1'b0, 32'h10, 4'h0}) begin
            errors++;
            $display("FAIL fetch_grant: got req=%b we=%b addr=%h strb=%h expected 1 0 00000010 0", mem_req, mem_we, mem_addr, mem_wstrb);
        end
        tick;
        tick;
        mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
        tick;
        mem_ack = 1'b0; if_req = 1'b0;
        checks++;
        if ({if_ready, if_err, if_rdata, d_ready, mem_req} !== {1'b1, 1'b0, 32'h13, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fetch_resp: got rdy=%b err=%b rdata=%h d_rdy=%b req=%b expected 1 0 00000013 0 0", if_ready, if_err, if_rdata, d_ready, mem_req);
        end
        tick;
        checks++;
        if ({if_ready, d_ready, busy} !== 3'b000) begin
            errors++;
            $display("FAIL fetch_pulse: got if_rdy=%b d_rdy=%b busy=%b expected 0 0 0", if_ready, d_ready, busy);
        end
    endtask

    task automatic test_collision;
        if_req = 1'b1; if_addr = 32'h0000_0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
        tick;
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
            errors++;
            $display("FAIL collision_data_first: got req=%b we=%b addr=%h expected 1 0 00000100", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        tick;
        mem_ack = 1'b0; d_req = 1'b0;
        checks++;
        if ({d_ready, d_rdata, if_ready} !== {1'b1, 32'hAAAA_5555, 1'b0}) begin
            errors++;
            $display("FAIL collision_data_resp: got d_rdy=%b d_rdata=%h if_rdy=%b expected 1 aaaa5555 0", d_ready, d_rdata, if_ready);
        end
        tick;
        tick;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin
            errors++;
            $display("FAIL collision_fetch_next: got req=%b addr=%h expected 1 00000040", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_0093;
        tick;
        mem_ack = 1'b0; if_req = 1'b0;
        tick;
    endtask

    task automatic test_starvation;
        logic [5:0] exp_fetch;
        logic       got_fetch;
        exp_fetch = 6'b01_0000;
        if_req = 1'b1; if_addr = 32'h0000_0A00;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0B00;
        for (int g = 0; g < 6; g++) begin
            int w;
            w = 0;
            while (mem_req !== 1'b1 && w < 10) begin
                tick;
                w++;
            end
            checks++;
            if (mem_req !== 1'b1) begin
                errors++;
                $display("FAIL starve_grant_wait: grant %0d got no mem_req, expected one within 10 cycles", g);
            end else begin
                got_fetch = (mem_addr == if_addr);
                if (got_fetch !== exp_fetch[g]) begin
                    errors++;
                    $display("FAIL starve_order: grant %0d got fetch=%b expected fetch=%b", g, got_fetch, exp_fetch[g]);
                end
                mem_ack = 1'b1; mem_rdata = 32'h5A5A_0000 + 32'(g);
                tick;
                mem_ack = 1'b0;
                if (!got_fetch) begin
                    last_d_load = 32'h5A5A_0000 + 32'(g);
                    d_addr = d_addr + 32'd4;
                end
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        tick; tick;
    endtask

    task automatic test_store;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        tick;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011}) begin
            errors++;
            $display("FAIL store_fields: got req=%b we=%b addr=%h wdata=%h strb=%b", mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick;
        mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        checks++;
        if ({d_ready, d_err, d_rdata, if_ready} !== {1'b1, 1'b0, last_d_load, 1'b0}) begin
            errors++;
            $display("FAIL store_resp: got rdy=%b err=%b rdata=%h expected 1 0 %h", d_ready, d_err, d_rdata, last_d_load);
        end
        tick;
        checks++;
        if ({d_ready, busy} !== 2'b00) begin
            errors++;
            $display("FAIL store_pulse: got rdy=%b busy=%b expected 0 0", d_ready, busy);
        end
    endtask

    task automatic test_timeout;
        int cnt;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        tick;
        cnt = 0;
        while (mem_req === 1'b1 && cnt < 40) begin
            cnt++;
            tick;
        end
        d_req = 1'b0;
        checks++;
        if (cnt != TO) begin
            errors++;
            $display("FAIL timeout_req_len: got %0d cycles of mem_req expected %0d", cnt, TO);
        end
        checks++;
        if ({d_ready, d_err, d_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL timeout_resp: got rdy=%b err=%b rdata=%h expected 1 1 00000000", d_ready, d_err, d_rdata);
        end
        tick;
        checks++;
        if ({busy, d_ready, d_err} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b rdy=%b err=%b expected 0 0 0", busy, d_ready, d_err);
        end
        d_req = 1'b1; d_addr = 32'h0000_0304;
        tick;
        repeat (TO - 1) tick;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL edge_req_held: got mem_req=%b at last watchdog cycle expected 1", mem_req);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick;
        mem_ack = 1'b0; d_req = 1'b0;
        checks++;
        if ({d_ready, d_err, d_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            errors++;
            $display("FAIL edge_ack_wins: got rdy=%b err=%b rdata=%h expected 1 0 12345678", d_ready, d_err, d_rdata);
        end
        tick;
    endtask

    task automatic test_async_reset;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0400; d_wdata = 32'hCAFE_0000; d_wstrb = 4'hF;
        tick;
        checks++;
        if ({mem_req, busy} !== 2'b11) begin
            errors++;
            $display("FAIL areset_pre: got req=%b busy=%b expected 1 1", mem_req, busy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_ready, if_rdata, if_err,
             d_ready, d_rdata, d_err, busy} !== '0) begin
            errors++;
            $display("FAIL areset_outputs: got req=%b we=%b addr=%h wdata=%h busy=%b expected all 0", mem_req, mem_we, mem_addr, mem_wdata, busy);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick; tick;
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0080;
        tick;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {1'b1, 1'b0, 32'h80, 4'h0}) begin
            errors++;
            $display("FAIL areset_first_grant: got req=%b we=%b addr=%h expected 1 0 00000080", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_0093;
        tick;
        mem_ack = 1'b0; if_req = 1'b0;
        checks++;
        if ({if_ready, if_err, if_rdata} !== {1'b1, 1'b0, 32'h93}) begin
            errors++;
            $display("FAIL areset_fetch: got rdy=%b err=%b rdata=%h expected 1 0 00000093", if_ready, if_err, if_rdata);
        end
        tick;
    endtask

    // Model: phase 0 idle, 1 memory outstanding, 2 response cycle; owner 1 fetch, 2 data.
    task automatic test_random;
        int phase, owner, streak, wait_cnt, delay, done;
        logic p_if, p_d, p_ack, wins_d;
        logic [31:0] exp_if, exp_d, g_addr;
        logic g_we;
        logic [3:0] g_strb;
        phase = 0; owner = 0; streak = 0; wait_cnt = 0; delay = 0; done = 0;
        p_if = 1'b0; p_d = 1'b0; p_ack = 1'b0;
        exp_if = '0; exp_d = '0; g_addr = '0; g_we = 1'b0; g_strb = '0;
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        tick;
        reset = 1'b1;
        for (int c = 0; c < 800; c++) begin
            tick;
            case (phase)
                0: if (p_if || p_d) begin
                    wins_d = p_d && (!p_if || streak < LIM);
                    if (wins_d) begin
                        streak = p_if ? ((streak < LIM) ? streak + 1 : LIM) : 0;
                        owner = 2; g_addr = d_addr; g_we = d_we; g_strb = d_wstrb;
                    end else begin
                        streak = 0;
                        owner = 1; g_addr = if_addr; g_we = 1'b0; g_strb = 4'h0;
                    end
                    phase = 1;
                    checks++;
                    if ({mem_we, mem_addr, mem_wstrb} !== {g_we, g_addr, g_strb} ||
                        (owner == 2 && mem_wdata !== d_wdata)) begin
                        errors++;
                        $display("FAIL rand_grant: cycle %0d got we=%b addr=%h strb=%h expected owner %0d we=%b addr=%h strb=%h", c, mem_we, mem_addr, mem_strb_dummy(mem_wstrb), owner, g_we, g_addr, g_strb);
                    end
                end
                1: if (p_ack) begin
                    phase = 2;
                    done++;
                    if (owner == 1) exp_if = mem_fn(g_addr);
                    else if (!g_we) exp_d = mem_fn(g_addr);
                    checks++;
                    if ({if_err, d_err, if_rdata, d_rdata} !== {2'b00, exp_if, exp_d}) begin
                        errors++;
                        $display("FAIL rand_resp: cycle %0d got err=%b%b if_rdata=%h d_rdata=%h expected 00 %h %h", c, if_err, d_err, if_rdata, d_rdata, exp_if, exp_d);
                    end
                end
                default: phase = 0;
            endcase
            checks++;
            if ({busy, mem_req, if_ready, d_ready} !==
                {phase != 0, phase == 1, phase == 2 && owner == 1, phase == 2 && owner == 2}) begin
                errors++;
                $display("FAIL rand_cycle: cycle %0d got busy=%b req=%b if_rdy=%b d_rdy=%b for phase %0d owner %0d", c, busy, mem_req, if_ready, d_ready, phase, owner);
            end
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (phase == 1) begin
                if (wait_cnt == delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_fn(g_addr);
                    wait_cnt = 0;
                    delay = $urandom_range(0, 4);
                end else begin
                    wait_cnt++;
                end
            end
            if (!if_req || (phase == 2 && owner == 1)) begin
                if_req = 1'($urandom_range(0, 1));
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req || (phase == 2 && owner == 2)) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom & 32'hFFFF_FFFC;
                d_wdata = $urandom;
                d_wstrb = 4'($urandom_range(0, 15));
            end
            p_if = if_req; p_d = d_req; p_ack = mem_ack;
        end
        checks++;
        if (done < 60) begin
            errors++;
            $display("FAIL rand_progress: got %0d completed transactions expected at least 60", done);
        end
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    endtask

    function automatic logic [3:0] mem_strb_dummy(input logic [3:0] s);
        return s;
    endfunction

    initial begin
        test_reset;
        test_single_fetch;
        test_collision;
        test_starvation;
        test_store;
        test_timeout;
        test_async_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
